// File: rtl/cu_pkg.sv
// Shared types and constants for the 16-bit processor control unit.
// Covers the state encodings, opcodes, ALU selects and the control-word layout.
package cu_pkg;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOADA  = 4'd4,
      S_LOADB  = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   typedef struct packed {
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] w_addr;
      logic       w_en;
      logic [3:0] ra_addr;
      logic [3:0] rb_addr;
      logic [2:0] alu_s;
   } ctrl_t;

   // All strobes inactive, all addresses zero.
   function automatic ctrl_t ctrl_idle();
      ctrl_t c;
      c.pc_clr  = 1'b0;
      c.pc_up   = 1'b0;
      c.ir_ld   = 1'b0;
      c.d_addr  = 8'h00;
      c.d_wr    = 1'b0;
      c.rf_s    = 1'b0;
      c.w_addr  = 4'h0;
      c.w_en    = 1'b0;
      c.ra_addr = 4'h0;
      c.rb_addr = 4'h0;
      c.alu_s   = ALU_PASS;
      return c;
   endfunction

endpackage

// File: rtl/cu_instr_decode.sv
// Combinational field split of the registered instruction word.
// Feeds both next-state selection and output generation in the control unit.
module cu_instr_decode
   import cu_pkg::*;
(
   input  logic [15:0] ir,
   output logic [3:0]  opcode,
   output logic [3:0]  rd,
   output logic [3:0]  rs_a,
   output logic [3:0]  rs_b,
   output logic [7:0]  addr
);

   assign opcode = ir[15:12];
   assign rd     = ir[11:8];
   assign rs_a   = ir[7:4];
   assign rs_b   = ir[3:0];
   assign addr   = ir[7:0];

endmodule

// File: rtl/control_unit.sv
// Moore FSM sequencing fetch/decode/execute for the 16-bit processor.
// Optional CU_SINGLE_STEP_EN adds a Step input that gates the Fetch state.
module control_unit
   import cu_pkg::*;
(
   input  logic        Clock,
   input  logic        ResetN,
   input  logic [15:0] IR,
`ifdef CU_SINGLE_STEP_EN
   input  logic        Step,
`endif
   output logic        PC_clr,
   output logic        PC_up,
   output logic        IR_ld,
   output logic [7:0]  D_addr,
   output logic        D_wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_addr,
   output logic [3:0]  RF_Rb_addr,
   output logic [2:0]  ALU_s0,
   output logic [3:0]  OutState
);

   state_t     state_r;
   state_t     next_state_s;
   ctrl_t      ctrl_s;
   ctrl_t      ctrl_r;
   logic       fetch_go_s;
   logic [3:0] opcode_s;
   logic [3:0] rd_s;
   logic [3:0] rs_a_s;
   logic [3:0] rs_b_s;
   logic [7:0] addr_s;

   cu_instr_decode u_decode (
      .ir     (IR),
      .opcode (opcode_s),
      .rd     (rd_s),
      .rs_a   (rs_a_s),
      .rs_b   (rs_b_s),
      .addr   (addr_s)
   );

`ifdef CU_SINGLE_STEP_EN
   assign fetch_go_s = Step;
`else
   assign fetch_go_s = 1'b1;
`endif

   // Next-state selection; Decode dispatches on the registered opcode.
   always_comb begin
      next_state_s = S_INIT;
      case (state_r)
         S_INIT:   next_state_s = S_FETCH;
         S_FETCH: begin
            if (fetch_go_s) begin
               next_state_s = S_DECODE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (opcode_s)
               OP_STORE: next_state_s = S_STORE;
               OP_LOAD:  next_state_s = S_LOADA;
               OP_ADD:   next_state_s = S_ADD;
               OP_SUB:   next_state_s = S_SUB;
               OP_HALT:  next_state_s = S_HALT;
               default:  next_state_s = S_NOOP;
            endcase
         end
         S_NOOP:   next_state_s = S_FETCH;
         S_LOADA:  next_state_s = S_LOADB;
         S_LOADB:  next_state_s = S_FETCH;
         S_STORE:  next_state_s = S_FETCH;
         S_ADD:    next_state_s = S_FETCH;
         S_SUB:    next_state_s = S_FETCH;
         S_HALT:   next_state_s = S_HALT;
         default:  next_state_s = S_INIT;
      endcase
   end

   // Control word for the state being entered, so outputs register alongside state.
   always_comb begin
      ctrl_s = ctrl_idle();
      case (next_state_s)
         S_INIT:  ctrl_s.pc_clr = 1'b1;
         S_FETCH: begin
            ctrl_s.ir_ld = 1'b1;
            ctrl_s.pc_up = 1'b1;
         end
         S_LOADA: begin
            ctrl_s.d_addr = addr_s;
            ctrl_s.rf_s   = 1'b1;
            ctrl_s.w_addr = rd_s;
         end
         S_LOADB: begin
            ctrl_s.d_addr = addr_s;
            ctrl_s.rf_s   = 1'b1;
            ctrl_s.w_addr = rd_s;
            ctrl_s.w_en   = 1'b1;
         end
         S_STORE: begin
            ctrl_s.d_addr  = addr_s;
            ctrl_s.ra_addr = rd_s;
            ctrl_s.d_wr    = 1'b1;
         end
         S_ADD: begin
            ctrl_s.ra_addr = rs_a_s;
            ctrl_s.rb_addr = rs_b_s;
            ctrl_s.w_addr  = rd_s;
            ctrl_s.alu_s   = ALU_ADD;
            ctrl_s.w_en    = 1'b1;
         end
         S_SUB: begin
            ctrl_s.ra_addr = rs_a_s;
            ctrl_s.rb_addr = rs_b_s;
            ctrl_s.w_addr  = rd_s;
            ctrl_s.alu_s   = ALU_SUB;
            ctrl_s.w_en    = 1'b1;
         end
         default: ctrl_s = ctrl_idle();
      endcase
   end

   // State and control-word registers; async reset kills write strobes at once.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_r       <= S_INIT;
         ctrl_r        <= ctrl_idle();
         ctrl_r.pc_clr <= 1'b1;
      end else begin
         state_r <= next_state_s;
         ctrl_r  <= ctrl_s;
      end
   end

`ifdef CU_SINGLE_STEP_EN
   assign IR_ld = ctrl_r.ir_ld & Step;
   assign PC_up = ctrl_r.pc_up & Step;
`else
   assign IR_ld = ctrl_r.ir_ld;
   assign PC_up = ctrl_r.pc_up;
`endif

   assign PC_clr     = ctrl_r.pc_clr;
   assign D_addr     = ctrl_r.d_addr;
   assign D_wr       = ctrl_r.d_wr;
   assign RF_s       = ctrl_r.rf_s;
   assign RF_W_addr  = ctrl_r.w_addr;
   assign RF_W_en    = ctrl_r.w_en;
   assign RF_Ra_addr = ctrl_r.ra_addr;
   assign RF_Rb_addr = ctrl_r.rb_addr;
   assign ALU_s0     = ctrl_r.alu_s;
   assign OutState   = state_r;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues hand-computed output
// vectors, a monitor pops and compares them on the falling clock edge.
module tb_control_unit;

   logic        Clock = 1'b0;
   logic        ResetN = 1'b0;
   logic [15:0] IR = 16'h0000;
`ifdef CU_SINGLE_STEP_EN
   logic        Step = 1'b1;
`endif
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
   logic [2:0]  ALU_s0;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   string       name_q[$];
   event        async_chk;

   control_unit dut (
      .Clock      (Clock),
      .ResetN     (ResetN),
      .IR         (IR),
`ifdef CU_SINGLE_STEP_EN
      .Step       (Step),
`endif
      .PC_clr     (PC_clr),
      .PC_up      (PC_up),
      .IR_ld      (IR_ld),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .OutState   (OutState)
   );

   always #5 Clock = ~Clock;

   // Output vector: {state, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu}
   function automatic logic [32:0] mk(input logic [3:0] st, input logic pcc, input logic pcu,
                                      input logic irl, input logic [7:0] da, input logic dw,
                                      input logic rfs, input logic [3:0] wa, input logic we,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [2:0] alu);
      return {st, pcc, pcu, irl, da, dw, rfs, wa, we, ra, rb, alu};
   endfunction

   task automatic expect_now(input string nm, input logic [32:0] v);
      exp_q.push_back(v);
      name_q.push_back(nm);
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Called one step after the edge entering Fetch; returns in the first execute state.
   task automatic fetch_decode(input logic [15:0] ir);
      IR = ir;
      expect_now("fetch", mk(4'd1, 1'b1 ^ 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      tick();
      expect_now("decode", mk(4'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      tick();
   endtask

   // Monitor: compares queued vectors against the DUT outputs.
   always @(negedge Clock or async_chk) begin
      if (exp_q.size() > 0) begin
         logic [32:0] act;
         logic [32:0] e;
         string       nm;
         act = {OutState, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
                RF_Ra_addr, RF_Rb_addr, ALU_s0};
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, e, $time);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held: Init with PC_clr only.
      tick();
      expect_now("reset_init", mk(4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      ResetN = 1'b1;
      tick();
      checks++;
      if (OutState !== 4'd1 || IR_ld !== 1'b1 || PC_up !== 1'b1) begin
         errors++;
         $display("FAIL release_fetch actual=%h/%b/%b expected=1/1/1 at %0t", OutState, IR_ld, PC_up, $time);
      end

      // LOAD R3,[0x05]: 4 cycles, write only in LoadB.
      fetch_decode(16'h2305);
      expect_now("loada", mk(4'd4, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 3'b000));
      tick();
      expect_now("loadb", mk(4'd5, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 4'h3, 1'b1, 4'h0, 4'h0, 3'b000));
      tick();

      // STORE [0x22],RA: D_wr for one cycle (next fetch vector checks it drops).
      fetch_decode(16'h1A22);
      checks++;
      if (D_wr !== 1'b1 || D_addr !== 8'h22) begin
         errors++;
         $display("FAIL store_direct actual=%b/%h expected=1/22 at %0t", D_wr, D_addr, $time);
      end
      expect_now("store", mk(4'd6, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 4'h0, 1'b0, 4'hA, 4'h0, 3'b000));
      tick();

      fetch_decode(16'h4123);
      expect_now("sub", mk(4'd8, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h1, 1'b1, 4'h2, 4'h3, 3'b010));
      tick();

      fetch_decode(16'h3123);
      expect_now("add", mk(4'd7, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h1, 1'b1, 4'h2, 4'h3, 3'b001));
      tick();

      // Unknown opcode and NOOP both take the 3-cycle NoOp path.
      fetch_decode(16'hF000);
      expect_now("unknown_noop", mk(4'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      tick();
      fetch_decode(16'h0000);
      expect_now("noop", mk(4'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      tick();

      // ADD then asynchronous reset in the middle of the Add cycle.
      fetch_decode(16'h3C5A);
      expect_now("add2", mk(4'd7, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'hC, 1'b1, 4'h5, 4'hA, 3'b001));
      @(negedge Clock);
      #2;
      ResetN = 1'b0;
      #1;
      checks++;
      if (RF_W_en !== 1'b0) begin
         errors++;
         $display("FAIL async_wen actual=%b expected=0 at %0t", RF_W_en, $time);
      end
      checks++;
      if (OutState !== 4'd0) begin
         errors++;
         $display("FAIL async_state actual=%h expected=0 at %0t", OutState, $time);
      end
      expect_now("async_reset_add", mk(4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      ->async_chk;
      tick();
      expect_now("reset_hold", mk(4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      ResetN = 1'b1;
      tick();

      // HALT: parked in state 9 for 20 cycles, left only by reset.
      fetch_decode(16'h5000);
      for (int i = 0; i < 20; i++) begin
         expect_now("halt", mk(4'd9, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
         tick();
      end
      checks++;
      if (OutState !== 4'd9) begin
         errors++;
         $display("FAIL halt_stay actual=%h expected=9 at %0t", OutState, $time);
      end
      ResetN = 1'b0;
      #1;
      expect_now("halt_reset", mk(4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      ->async_chk;
      tick();
      ResetN = 1'b1;
      tick();
      expect_now("refetch", mk(4'd1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
      @(negedge Clock);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
